// File: rtl/hazard_sb_ctrl_pkg.sv
// Shared types and default constants for the scoreboard-based hazard controller.
// Also holds the helper that picks the redirect target for an exception.
package hazard_sb_ctrl_pkg;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
   localparam logic [31:0] ERET_CODE_DEF  = 32'h0000000e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } ctrl_state_t;

   // ERET returns to the saved EPC; every other exception enters the common vector.
   function automatic logic [31:0] exc_target(input logic        is_eret,
                                              input logic [31:0] epc,
                                              input logic [31:0] vector);
      return is_eret ? epc : vector;
   endfunction

endpackage

// File: rtl/hazard_sb_ctrl_if.sv
// Datapath-side bundle for the hazard controller.
// The master modport is the datapath side; the slave modport is the controller.
interface hazard_sb_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int EXC_W  = 32
);
   logic [REG_AW-1:0] rs_d;
   logic [REG_AW-1:0] rt_d;
   logic              rs_used_d;
   logic              rt_used_d;
   logic              issue_d;
   logic [REG_AW-1:0] wreg_d;
   logic              long_wr_d;
   logic              long_wb_w;
   logic [REG_AW-1:0] wreg_w;
   logic [EXC_W-1:0]  excepttype_w;
   logic [31:0]       epc_w;

   logic              stall_f;
   logic              stall_d;
   logic              flush_f;
   logic              flush_d;
   logic              flush_e;
   logic              flush_m;
   logic              flush_w;
   logic              redirect_valid;
   logic [31:0]       newpc;
   logic              sb_busy;
   logic              stall_timeout;

   modport master (
      output rs_d, rt_d, rs_used_d, rt_used_d, issue_d, wreg_d, long_wr_d,
             long_wb_w, wreg_w, excepttype_w, epc_w,
      input  stall_f, stall_d, flush_f, flush_d, flush_e, flush_m, flush_w,
             redirect_valid, newpc, sb_busy, stall_timeout
   );

   modport slave (
      input  rs_d, rt_d, rs_used_d, rt_used_d, issue_d, wreg_d, long_wr_d,
             long_wb_w, wreg_w, excepttype_w, epc_w,
      output stall_f, stall_d, flush_f, flush_d, flush_e, flush_m, flush_w,
             redirect_valid, newpc, sb_busy, stall_timeout
   );
endinterface

// File: rtl/hazard_sb_ctrl_scoreboard.sv
// Per-register pending-write scoreboard with set, clear and whole-table flush.
// It provides read ports for both decode sources and the issuing destination.
module hz_scoreboard #(
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_idx,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_idx,
   input  logic              flush_clr,
   input  logic [REG_AW-1:0] rs_idx,
   input  logic [REG_AW-1:0] rt_idx,
   input  logic [REG_AW-1:0] wd_idx,
   output logic              rs_pend,
   output logic              rt_pend,
   output logic              wd_pend,
   output logic              busy
);
   localparam int NREG = 2 ** REG_AW;

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nx;

   // The set is applied after the clear so that it wins on a same-register collision.
   // Register 0 is hardwired and can never be pending.
   always_comb begin
      pend_nx = pend;
      if (clr_en)
         pend_nx[clr_idx] = 1'b0;
      if (set_en)
         pend_nx[set_idx] = 1'b1;
      pend_nx[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst || flush_clr)
         pend <= '0;
      else
         pend <= pend_nx;
   end

   assign rs_pend = pend[rs_idx];
   assign rt_pend = pend[rt_idx];
   assign wd_pend = pend[wd_idx];
   assign busy    = |pend;

endmodule

// File: rtl/hazard_sb_ctrl.sv
// Top-level hazard controller: scoreboard stalls, exception flush/redirect FSM,
// and a sticky watchdog that trips on runaway stalls.
module hazard_sb_ctrl
   import hazard_sb_ctrl_pkg::*;
#(
   parameter int                REG_AW       = 5,
   parameter int                EXC_W        = 32,
   parameter logic [31:0]       EXC_VECTOR   = EXC_VECTOR_DEF,
   parameter logic [EXC_W-1:0]  ERET_CODE    = EXC_W'(ERET_CODE_DEF),
   parameter int                FLUSH_CYCLES = 1,
   parameter int                MAX_STALL    = 64
) (
   input logic             clk,
   input logic             rst,
   hazard_sb_ctrl_if.slave bus
);
   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam int SC_W = $clog2(MAX_STALL + 1);
   localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);
   localparam logic [SC_W-1:0] STALL_MAX  = SC_W'(MAX_STALL);

   ctrl_state_t     state;
   logic [FC_W-1:0] flush_cnt;
   logic [31:0]     newpc_q;
   logic [SC_W-1:0] stall_cnt;
   logic            timeout_q;

   logic        exc;
   logic        accept;
   logic        flushing;
   logic        hazard;
   logic        stall;
   logic [31:0] target;
   logic        rs_pend;
   logic        rt_pend;
   logic        wd_pend;
   logic        busy;

   assign exc      = (bus.excepttype_w != '0);
   assign accept   = (state == ST_IDLE) && exc;
   assign flushing = accept || (state == ST_FLUSH);
   assign target   = exc_target(bus.excepttype_w == ERET_CODE, bus.epc_w, EXC_VECTOR);

   // Hazard looks only at the registered pend state, so a writeback in this cycle
   // does not release the consumer until the following cycle.
   assign hazard = (bus.rs_used_d && rs_pend && (bus.rs_d != '0)) ||
                   (bus.rt_used_d && rt_pend && (bus.rt_d != '0)) ||
                   (bus.long_wr_d && wd_pend && (bus.wreg_d != '0));
   assign stall  = hazard && !flushing;

   hz_scoreboard #(
      .REG_AW (REG_AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (bus.issue_d && bus.long_wr_d && !stall),
      .set_idx   (bus.wreg_d),
      .clr_en    (bus.long_wb_w && (state == ST_IDLE)),
      .clr_idx   (bus.wreg_w),
      .flush_clr (accept),
      .rs_idx    (bus.rs_d),
      .rt_idx    (bus.rt_d),
      .wd_idx    (bus.wreg_d),
      .rs_pend   (rs_pend),
      .rt_pend   (rt_pend),
      .wd_pend   (wd_pend),
      .busy      (busy)
   );

   // Exception sequencer: the accept cycle latches the target and arms the
   // countdown; FLUSH ignores further exceptions until the count reaches 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
         newpc_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (exc) begin
                  newpc_q   <= target;
                  flush_cnt <= FLUSH_LOAD;
                  state     <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == FC_W'(1))
                  state <= ST_IDLE;
               else
                  flush_cnt <= flush_cnt - FC_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Watchdog counts consecutive stall cycles, saturating, with a sticky flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         timeout_q <= 1'b0;
      end else if (stall) begin
         if (stall_cnt != STALL_MAX)
            stall_cnt <= stall_cnt + SC_W'(1);
         if (stall_cnt >= STALL_MAX - SC_W'(1))
            timeout_q <= 1'b1;
      end else begin
         stall_cnt <= '0;
      end
   end

   assign bus.stall_f        = stall;
   assign bus.stall_d        = stall;
   assign bus.flush_f        = flushing;
   assign bus.flush_d        = flushing;
   assign bus.flush_e        = stall || flushing;
   assign bus.flush_m        = flushing;
   assign bus.flush_w        = flushing;
   assign bus.redirect_valid = accept;
   assign bus.newpc          = accept ? target : newpc_q;
   assign bus.sb_busy        = busy;
   assign bus.stall_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// Directed bench for hazard_sb_ctrl with FLUSH_CYCLES=2 and MAX_STALL=4.
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_hazard_sb_ctrl;
   localparam int REG_AW = 5;
   localparam int EXC_W  = 32;

   logic clk;
   logic rst;
   int   checks;
   int   passes;

   hazard_sb_ctrl_if #(.REG_AW(REG_AW), .EXC_W(EXC_W)) b ();

   hazard_sb_ctrl #(
      .REG_AW       (REG_AW),
      .EXC_W        (EXC_W),
      .FLUSH_CYCLES (2),
      .MAX_STALL    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual === expected)
         passes++;
      else
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input int issue, input int long_wr, input int wreg,
                                input int rs, input int rs_used, input int rt,
                                input int rt_used, input int long_wb, input int wreg_w,
                                input int exc, input logic [31:0] epc);
      @(negedge clk);
      b.issue_d      = 1'(issue);
      b.long_wr_d    = 1'(long_wr);
      b.wreg_d       = REG_AW'(wreg);
      b.rs_d         = REG_AW'(rs);
      b.rs_used_d    = 1'(rs_used);
      b.rt_d         = REG_AW'(rt);
      b.rt_used_d    = 1'(rt_used);
      b.long_wb_w    = 1'(long_wb);
      b.wreg_w       = REG_AW'(wreg_w);
      b.excepttype_w = EXC_W'(exc);
      b.epc_w        = epc;
      #1;
   endtask

   task automatic applyIdle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst            = 1'b1;
      b.issue_d      = 1'b0;
      b.long_wr_d    = 1'b0;
      b.rs_used_d    = 1'b0;
      b.rt_used_d    = 1'b0;
      b.long_wb_w    = 1'b0;
      b.excepttype_w = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   function automatic logic [31:0] flushVec();
      return 32'({b.flush_f, b.flush_d, b.flush_e, b.flush_m, b.flush_w});
   endfunction

   initial begin
      checks = 0;
      passes = 0;
      rst    = 1'b1;
      b.issue_d = 1'b0; b.long_wr_d = 1'b0; b.wreg_d = '0;
      b.rs_d = '0; b.rs_used_d = 1'b0; b.rt_d = '0; b.rt_used_d = 1'b0;
      b.long_wb_w = 1'b0; b.wreg_w = '0; b.excepttype_w = '0; b.epc_w = '0;

      // Reset values
      applyIdle();
      applyIdle();
      checkOutput("rst_stall",    32'(b.stall_d), 0);
      checkOutput("rst_flush",    flushVec(), 0);
      checkOutput("rst_redirect", 32'(b.redirect_valid), 0);
      checkOutput("rst_newpc",    b.newpc, 0);
      checkOutput("rst_busy",     32'(b.sb_busy), 0);
      checkOutput("rst_timeout",  32'(b.stall_timeout), 0);
      rst = 1'b0;

      // Load to $5 followed by a consumer of $5
      applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("ld5_issue_stall", 32'(b.stall_d), 0);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("raw5_stall_f", 32'(b.stall_f), 1);
      checkOutput("raw5_stall_d", 32'(b.stall_d), 1);
      checkOutput("raw5_flush_e", flushVec(), 32'b00100);
      checkOutput("raw5_busy",    32'(b.sb_busy), 1);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 1, 5, 0, 32'h0);
      checkOutput("raw5_wb_cycle_stall", 32'(b.stall_d), 1);
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("raw5_after_wb_stall", 32'(b.stall_d), 0);
      checkOutput("raw5_after_wb_flush", flushVec(), 0);
      checkOutput("raw5_after_wb_busy",  32'(b.sb_busy), 0);

      // Register $0 never becomes pending
      applyStimulus(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0);
      checkOutput("r0_issue_stall", 32'(b.stall_d), 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h0);
      checkOutput("r0_use_stall", 32'(b.stall_d), 0);
      checkOutput("r0_busy",      32'(b.sb_busy), 0);

      // Same-cycle clear and set of $7: set wins
      applyStimulus(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 32'h0);
      checkOutput("r7_setclr_stall", 32'(b.stall_d), 0);
      applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 32'h0);
      checkOutput("r7_rt_stall", 32'(b.stall_d), 1);
      checkOutput("r7_busy",     32'(b.sb_busy), 1);
      applyStimulus(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 32'h0);
      checkOutput("r7_waw_stall", 32'(b.stall_d), 1);
      applyIdle();
      checkOutput("r7_cleared_busy", 32'(b.sb_busy), 0);
      checkOutput("r7_timeout",      32'(b.stall_timeout), 0);

      // Exception 0x4 with a pending $9 and a same-cycle issue to $10
      applyStimulus(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      applyStimulus(1, 1, 10, 9, 1, 0, 0, 0, 0, 4, 32'h0);
      checkOutput("exc4_t_flush",    flushVec(), 32'b11111);
      checkOutput("exc4_t_redirect", 32'(b.redirect_valid), 1);
      checkOutput("exc4_t_newpc",    b.newpc, 32'hBFC00380);
      checkOutput("exc4_t_stall",    32'(b.stall_d), 0);
      applyStimulus(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("exc4_t1_flush",    flushVec(), 32'b11111);
      checkOutput("exc4_t1_redirect", 32'(b.redirect_valid), 0);
      checkOutput("exc4_t1_newpc",    b.newpc, 32'hBFC00380);
      checkOutput("exc4_t1_busy",     32'(b.sb_busy), 0);
      applyStimulus(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("exc4_t2_flush",    flushVec(), 32'b11111);
      checkOutput("exc4_t2_redirect", 32'(b.redirect_valid), 0);
      applyStimulus(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("exc4_t3_flush", flushVec(), 0);
      checkOutput("exc4_t3_stall", 32'(b.stall_d), 0);
      checkOutput("exc4_t3_busy",  32'(b.sb_busy), 0);

      // ERET redirects to EPC; a second exception during FLUSH is ignored
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'he, 32'h80001234);
      checkOutput("eret_t_redirect", 32'(b.redirect_valid), 1);
      checkOutput("eret_t_newpc",    b.newpc, 32'h80001234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h0);
      checkOutput("eret_t1_redirect", 32'(b.redirect_valid), 0);
      checkOutput("eret_t1_newpc",    b.newpc, 32'h80001234);
      checkOutput("eret_t1_flush",    flushVec(), 32'b11111);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h0);
      checkOutput("eret_t2_redirect", 32'(b.redirect_valid), 0);
      applyIdle();
      checkOutput("eret_t3_flush",    flushVec(), 0);
      checkOutput("eret_t3_redirect", 32'(b.redirect_valid), 0);
      checkOutput("eret_t3_newpc",    b.newpc, 32'h80001234);

      // Reset in the middle of FLUSH
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 32'h0);
      doReset();
      checkOutput("rstflush_flush",    flushVec(), 0);
      checkOutput("rstflush_redirect", 32'(b.redirect_valid), 0);
      checkOutput("rstflush_newpc",    b.newpc, 0);

      // Watchdog with MAX_STALL=4 and $3 never written back
      applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      for (int i = 1; i <= 3; i++)
         applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("wd_stall4_timeout", 32'(b.stall_timeout), 0);
      checkOutput("wd_stall4_stall",   32'(b.stall_d), 1);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("wd_stall5_timeout", 32'(b.stall_timeout), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 32'h0);
      applyIdle();
      checkOutput("wd_sticky_timeout", 32'(b.stall_timeout), 1);
      checkOutput("wd_sticky_stall",   32'(b.stall_d), 0);

      // Reset in the middle of a stall clears pend and the watchdog
      applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("rststall_pre_stall", 32'(b.stall_d), 1);
      doReset();
      checkOutput("rststall_timeout", 32'(b.stall_timeout), 0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 32'h0);
      checkOutput("rststall_stall", 32'(b.stall_d), 0);
      checkOutput("rststall_busy",  32'(b.sb_busy), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
